match_row_cache: RTL and testbench

Double-buffered row cache feeding the phase-match core. Accepts one row of right-camera absolute phase as a stream of BEAT_SIZE-pixel beats and stores it as ROW_SIZE/WIN_SIZE window lines of WIN_SIZE pixels each. It then serves whole-window reads to the match core with a fixed read latency. Two row banks let row N+1 be written while row N is being matched.

---
 rtl/match_row_cache.sv | 143 ++++++++++++++
 tb/tb_match_row_cache.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_row_cache.sv
// match_row_cache
//   Double-buffered row cache for the phase-match core. A row of right-camera
//   absolute phase arrives as BEAT_SIZE-pixel beats and is stored as NUM_WIN
//   window lines of WIN_SIZE pixels. The match core reads whole window lines
//   with a fixed READ_LATENCY. Two banks let the next row be written while the
//   current one is matched.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   s_data/s_valid/s_ready/s_last   beat stream in (pixel k at [k*DATA_WIDTH +: DATA_WIDTH])
//   rd_addr         window line index, sampled every cycle
//   rd_data         window line, READ_LATENCY cycles after rd_addr
//   row_vld         read bank holds a complete row
//   row_done        consumer releases the read bank (ignored when ~row_vld)
//   row_err         one-cycle pulse: s_last position did not match row length
module match_row_cache #(
    parameter int ROW_SIZE     = 1280,
    parameter int WIN_SIZE     = 128,
    parameter int BEAT_SIZE    = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    localparam int NUM_WIN     = ROW_SIZE / WIN_SIZE,
    localparam int AW          = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            s_last,
    input  logic [AW-1:0]                   rd_addr,
    output logic [WIN_SIZE*DATA_WIDTH-1:0]  rd_data,
    output logic                            row_vld,
    input  logic                            row_done,
    output logic                            row_err
);

    localparam int BPW    = WIN_SIZE / BEAT_SIZE;
    localparam int BPR    = ROW_SIZE / BEAT_SIZE;
    localparam int BEAT_W = BEAT_SIZE * DATA_WIDTH;
    localparam int LINE_W = WIN_SIZE * DATA_WIDTH;
    localparam int BW     = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int MAW    = $clog2(2 * BPR);

    // Flat beat-slot storage: bank b, line l, slot s lives at b*BPR + l*BPW + s,
    // so the write address is simply bank base + running beat count.
    logic [BEAT_W-1:0] mem [2*BPR];

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [BW-1:0] wr_beat_q, wr_beat_d;
    logic          row_err_q, row_err_d;
    logic [LINE_W-1:0] rd_pipe_q [READ_LATENCY];
    logic [LINE_W-1:0] rd_pipe_d [READ_LATENCY];

    logic           acc, at_end, close, done;
    logic [MAW-1:0] wr_idx, rd_base;
    logic           rd_in_range;
    logic [LINE_W-1:0] rd_line;

    assign s_ready = ~full_q[wr_bank_q] & ~rst;
    assign row_vld = full_q[rd_bank_q];
    assign row_err = row_err_q;
    assign rd_data = rd_pipe_q[READ_LATENCY-1];

    assign acc    = s_valid & s_ready;
    assign at_end = (wr_beat_q == BW'(BPR - 1));
    assign close  = acc & (s_last | at_end);
    assign done   = row_done & row_vld;
    assign wr_idx = (wr_bank_q ? MAW'(BPR) : '0) + MAW'(wr_beat_q);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_beat_d = wr_beat_q;
        row_err_d = 1'b0;
        if (acc) begin
            row_err_d = s_last ^ at_end;
            wr_beat_d = wr_beat_q + BW'(1);
        end
        if (close) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_beat_d         = '0;
        end
        // A full bank is never the write bank, so this never collides with
        // the close update above.
        if (done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Read mux sees memory contents before this cycle's write lands.
    assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(NUM_WIN));
    assign rd_base     = (rd_bank_q ? MAW'(BPR) : '0) + MAW'(rd_addr) * MAW'(BPW);

    always_comb begin
        rd_line = '0;
        if (rd_in_range) begin
            for (int s = 0; s < BPW; s++) begin
                rd_line[s*BEAT_W +: BEAT_W] = mem[rd_base + MAW'(s)];
            end
        end
    end

    always_comb begin
        rd_pipe_d[0] = rd_line;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_beat_q <= '0;
            row_err_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_beat_q <= wr_beat_d;
            row_err_q <= row_err_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wr_idx] <= s_data;
        end
    end

endmodule

// File: tb/tb_match_row_cache.sv
module tb_match_row_cache;

    localparam int ROW  = 1280;
    localparam int WIN  = 128;
    localparam int BEAT = 8;
    localparam int DW   = 16;
    localparam int RL   = 2;
    localparam int NW   = ROW / WIN;
    localparam int BPR  = ROW / BEAT;
    localparam int AW   = 4;
    localparam int LW   = WIN * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BEAT*DW-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              s_last = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [LW-1:0]     rd_data;
    logic              row_vld;
    logic              row_done = 1'b0;
    logic              row_err;

    match_row_cache dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .rd_addr(rd_addr), .rd_data(rd_data), .row_vld(row_vld),
        .row_done(row_done), .row_err(row_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    bit rnd = 0;

    // ---------------- behavioural model: a row of pixels per bank ----------
    logic [DW-1:0] m_pix   [2][ROW];
    bit            m_known [2][ROW];
    bit [1:0]      m_full;
    bit            m_wb, m_rb, m_err;
    int            m_beat;
    logic [LW-1:0] m_pipe [RL];
    logic [LW-1:0] m_mask [RL];
    logic [LW-1:0] nl, nk;
    bit            m_acc, m_done, m_ob, m_orb, m_endpos;

    initial begin
        for (int b = 0; b < 2; b++) for (int c = 0; c < ROW; c++) m_known[b][c] = 0;
        for (int i = 0; i < RL; i++) begin m_pipe[i] = '0; m_mask[i] = '0; end
        m_full = 0; m_wb = 0; m_rb = 0; m_beat = 0; m_err = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_full = 0; m_wb = 0; m_rb = 0; m_beat = 0; m_err = 0;
                for (int i = 0; i < RL; i++) begin m_pipe[i] = '0; m_mask[i] = '1; end
            end else begin
                nl = '0; nk = '1;
                if (int'(rd_addr) < NW) begin
                    for (int i = 0; i < WIN; i++) begin
                        nl[i*DW +: DW] = m_pix[m_rb][int'(rd_addr)*WIN + i];
                        nk[i*DW +: DW] = m_known[m_rb][int'(rd_addr)*WIN + i] ? {DW{1'b1}} : {DW{1'b0}};
                    end
                end
                for (int i = RL-1; i > 0; i--) begin m_pipe[i] = m_pipe[i-1]; m_mask[i] = m_mask[i-1]; end
                m_pipe[0] = nl; m_mask[0] = nk;
                m_ob = m_wb; m_orb = m_rb;
                m_acc  = s_valid && !m_full[m_ob];
                m_done = row_done && m_full[m_orb];
                m_err  = 0;
                if (m_acc) begin
                    for (int k = 0; k < BEAT; k++) begin
                        m_pix[m_ob][m_beat*BEAT + k]   = s_data[k*DW +: DW];
                        m_known[m_ob][m_beat*BEAT + k] = 1;
                    end
                    m_endpos = (m_beat == BPR-1);
                    m_err = (s_last != m_endpos);
                    if (s_last || m_endpos) begin
                        m_full[m_ob] = 1; m_wb = !m_ob; m_beat = 0;
                    end else m_beat++;
                end
                if (m_done) begin m_full[m_orb] = 0; m_rb = !m_orb; end
            end
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [LW-1:0] act,
                            input logic [LW-1:0] exp, input logic [LW-1:0] msk);
        logic [LW-1:0] diff;
        diff = (act ^ exp) & msk;
        checks++;
        if (diff !== '0) begin
            failures++;
            for (int i = 0; i < WIN; i++) begin
                if (diff[i*DW +: DW] !== '0) begin
                    $display("FAIL %s pixel=%0d actual=%0h required=%0h",
                             nm, i, act[i*DW +: DW], exp[i*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [LW-1:0] ramp(input int base);
        logic [LW-1:0] l;
        for (int i = 0; i < WIN; i++) l[i*DW +: DW] = DW'(base + i);
        return l;
    endfunction

    // Per-cycle compare against the model, 1 time unit after the falling edge.
    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            chk("s_ready", {31'd0, s_ready}, {31'd0, !rst && !m_full[m_wb]});
            chk("row_vld", {31'd0, row_vld}, {31'd0, m_full[m_rb]});
            chk("row_err", {31'd0, row_err}, {31'd0, m_err});
            if (m_mask[RL-1] != '0) chk_line("rd_data", rd_data, m_pipe[RL-1], m_mask[RL-1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (rnd) begin
            rd_addr  = AW'($urandom_range(0, 15));
            row_done = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic send_beat(input logic [BEAT*DW-1:0] d, input bit last, input bit done_too);
        int n;
        s_data = d; s_last = last; s_valid = 1'b1;
        if (done_too) row_done = 1'b1;
        n = 0;
        while (!s_ready && n < 2000) begin tick(); n++; end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL s_ready_timeout actual=0 required=1");
        end
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        if (done_too) row_done = 1'b0;
    endtask

    task automatic send_row(input int nb, input int last_at, input int base,
                            input bit rdata, input bit done_last);
        logic [BEAT*DW-1:0] d;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < BEAT; k++)
                d[k*DW +: DW] = rdata ? DW'($urandom) : DW'(base + b*BEAT + k);
            send_beat(d, (b == last_at), done_last && (b == last_at));
        end
    endtask

    task automatic pulse_done();
        row_done = 1'b1; tick(); row_done = 1'b0;
    endtask

    logic [LW-1:0] exp_line;

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_row_vld", {31'd0, row_vld}, 32'd0);
        chk("rst_row_err", {31'd0, row_err}, 32'd0);
        chk_line("rst_rd_data", rd_data, '0, '1);
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Single row, pixel = column index
        send_row(BPR, BPR-1, 0, 0, 0);
        chk("t1_row_vld", {31'd0, row_vld}, 32'd1);
        chk("t1_row_err", {31'd0, row_err}, 32'd0);
        rd_addr = 4'd3;
        tick(); tick();
        chk_line("t1_line3", rd_data, ramp(384), '1);
        rd_addr = 4'd15;
        tick(); tick();
        chk_line("t1_oor", rd_data, '0, '1);

        // Back-pressure: second row fills bank 1, both banks full
        send_row(BPR, BPR-1, 1000, 0, 0);
        chk("t2_s_ready_low", {31'd0, s_ready}, 32'd0);
        tick(); tick();
        pulse_done();
        chk("t2_s_ready_back", {31'd0, s_ready}, 32'd1);
        send_row(BPR, BPR-1, 2000, 0, 0);   // lands in bank 0
        rd_addr = 4'd0;
        tick(); tick();
        chk_line("t2_rowB_line0", rd_data, ramp(1000), '1);
        pulse_done();                        // read bank -> bank 0 (row C)
        rd_addr = 4'd1;
        tick(); tick();
        chk_line("t2_rowC_line1", rd_data, ramp(2000 + 128), '1);

        // Ping-pong: row_done in the cycle row D closes
        send_row(BPR, BPR-1, 3000, 0, 1);
        chk("t3_row_vld", {31'd0, row_vld}, 32'd1);
        rd_addr = 4'd9;
        tick(); tick();
        chk_line("t3_rowD_line9", rd_data, ramp(3000 + 9*128), '1);

        // Short row: s_last on beat 99 into bank 0 (stale row C data behind it)
        send_row(100, 99, 5000, 0, 0);
        chk("t4_row_err_pulse", {31'd0, row_err}, 32'd1);
        tick();
        chk("t4_row_err_clear", {31'd0, row_err}, 32'd0);
        pulse_done();
        chk("t4_row_vld", {31'd0, row_vld}, 32'd1);
        rd_addr = 4'd6;
        tick(); tick();
        for (int i = 0; i < WIN; i++)
            exp_line[i*DW +: DW] = (i < 32) ? DW'(5000 + 768 + i) : DW'(2000 + 768 + i);
        chk_line("t4_line6_mixed", rd_data, exp_line, '1);
        rd_addr = 4'd5;
        tick(); tick();
        chk_line("t4_line5_new", rd_data, ramp(5000 + 640), '1);

        // Reset mid-row
        send_row(80, -1, 6000, 0, 0);
        rst = 1'b1;
        tick(); tick();
        chk("t5_rst_row_vld", {31'd0, row_vld}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t5_s_ready", {31'd0, s_ready}, 32'd1);
        send_row(BPR, BPR-1, 7000, 0, 0);
        chk("t5_row_vld", {31'd0, row_vld}, 32'd1);
        rd_addr = 4'd2;
        tick(); tick();
        chk_line("t5_rowE_line2", rd_data, ramp(7000 + 256), '1);
        pulse_done();

        // Randomized rows: full, short and overlong, with random reads/releases
        rnd = 1;
        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 2))
                0: send_row(BPR, BPR-1, 0, 1, 0);
                1: begin
                    int n;
                    n = $urandom_range(1, BPR-1);
                    send_row(n, n-1, 0, 1, 0);
                end
                default: send_row(BPR + $urandom_range(1, 20), -1, 0, 1, 0);
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        rnd = 0;
        row_done = 1'b0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
